// File: rtl/metaball_field_if.sv
// Pixel-side bundle between the vga timing block, the metaball field and the RGB pins.
// The master drives scan position and sync; the slave returns the shaded pixel.
interface metaball_field_if #(
  parameter int LEVEL_BITS = 3
);
  logic [9:0]            x;
  logic [9:0]            y;
  logic                  display;
  logic                  v_sync;
  logic                  pix;
  logic [LEVEL_BITS-1:0] level;
  logic                  display_out;

  modport master (
    output x, y, display, v_sync,
    input  pix, level, display_out
  );

  modport slave (
    input  x, y, display, v_sync,
    output pix, level, display_out
  );
endinterface

// File: rtl/metaball_field.sv
// N bouncing balls whose soft fields are summed per pixel so nearby balls merge.
// Three-stage pipeline: distance, field contribution, sum/threshold.
module metaball_field #(
  parameter int NUM_BALLS     = 2,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_SPEED    = 5,
  parameter int RADIUS_SQ     = 625,
  parameter int THRESHOLD     = 400,
  parameter int LEVEL_BITS    = 3,
  parameter int LEVEL_SHIFT   = 6,
  parameter logic [10*NUM_BALLS-1:0] BALL_X_INIT = {10'd500, 10'd150},
  parameter logic [10*NUM_BALLS-1:0] BALL_Y_INIT = {10'd300, 10'd100}
) (
  input logic             clk_100mhz,
  input logic             reset_n,
  metaball_field_if.slave vga
);
  localparam int MAX_LVL = (1 << LEVEL_BITS) - 1;

  logic [9:0]  bx    [NUM_BALLS];
  logic [9:0]  by    [NUM_BALLS];
  logic        neg_x [NUM_BALLS];
  logic        neg_y [NUM_BALLS];
  logic [10:0] nx    [NUM_BALLS];
  logic [10:0] ny    [NUM_BALLS];
  logic        v_sync_q;
  logic        tick;

  logic [7:0]  dx_q [NUM_BALLS];
  logic [7:0]  dy_q [NUM_BALLS];
  logic [15:0] c_q  [NUM_BALLS];
  logic        disp_q1;
  logic        disp_q2;
  logic [17:0] sum;
  logic [17:0] sum_sh;
  logic [LEVEL_BITS-1:0] lvl;

  logic                  pix_q;
  logic [LEVEL_BITS-1:0] level_q;
  logic                  disp_q3;

  // {flip, next_pos}: clamp at the edge and flip, never wrap
  function automatic logic [10:0] step(
    input logic [9:0] pos,
    input logic       neg,
    input int         lim
  );
    int p;
    p = int'(pos);
    if (!neg) begin
      if (p + BALL_SPEED > lim - 1) step = {1'b1, 10'(lim - 1)};
      else step = {1'b0, 10'(p + BALL_SPEED)};
    end else begin
      if (p < BALL_SPEED) step = {1'b1, 10'd0};
      else step = {1'b0, 10'(p - BALL_SPEED)};
    end
  endfunction

  function automatic logic [7:0] dist8(
    input logic [9:0] a,
    input logic [9:0] b
  );
    logic [9:0] d;
    d = (a >= b) ? a - b : b - a;
    dist8 = (d > 10'd255) ? 8'hff : d[7:0];
  endfunction

  function automatic logic [15:0] field(
    input logic [7:0] dx,
    input logic [7:0] dy
  );
    logic [15:0] ax;
    logic [15:0] ay;
    int          d2;
    ax = {8'd0, dx};
    ay = {8'd0, dy};
    d2 = int'({1'b0, ax * ax} + {1'b0, ay * ay});
    field = (d2 < RADIUS_SQ) ? 16'(RADIUS_SQ - d2) : 16'd0;
  endfunction

  assign tick = v_sync_q & ~vga.v_sync;

  always_comb begin
    for (int k = 0; k < NUM_BALLS; k++) begin
      nx[k] = step(bx[k], neg_x[k], SCREEN_WIDTH);
      ny[k] = step(by[k], neg_y[k], SCREEN_HEIGHT);
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      v_sync_q <= 1'b1;
      for (int k = 0; k < NUM_BALLS; k++) begin
        bx[k]    <= BALL_X_INIT[10*k +: 10];
        by[k]    <= BALL_Y_INIT[10*k +: 10];
        neg_x[k] <= 1'(k % 2);
        neg_y[k] <= 1'(k % 2);
      end
    end else begin
      v_sync_q <= vga.v_sync;
      if (tick) begin
        for (int k = 0; k < NUM_BALLS; k++) begin
          bx[k]    <= nx[k][9:0];
          by[k]    <= ny[k][9:0];
          neg_x[k] <= neg_x[k] ^ nx[k][10];
          neg_y[k] <= neg_y[k] ^ ny[k][10];
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_BALLS; k++) sum = sum + 18'(c_q[k]);
    sum_sh = sum >> LEVEL_SHIFT;
    lvl = (sum_sh > 18'(MAX_LVL)) ? LEVEL_BITS'(MAX_LVL)
                                  : sum_sh[LEVEL_BITS-1:0];
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BALLS; k++) begin
        dx_q[k] <= '0;
        dy_q[k] <= '0;
        c_q[k]  <= '0;
      end
      disp_q1 <= 1'b0;
      disp_q2 <= 1'b0;
      disp_q3 <= 1'b0;
      pix_q   <= 1'b0;
      level_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BALLS; k++) begin
        dx_q[k] <= dist8(vga.x, bx[k]);
        dy_q[k] <= dist8(vga.y, by[k]);
        c_q[k]  <= field(dx_q[k], dy_q[k]);
      end
      disp_q1 <= vga.display;
      disp_q2 <= disp_q1;
      disp_q3 <= disp_q2;
      pix_q   <= disp_q2 && (sum >= 18'(THRESHOLD));
      level_q <= disp_q2 ? lvl : '0;
    end
  end

  assign vga.pix         = pix_q;
  assign vga.level       = level_q;
  assign vga.display_out = disp_q3;
endmodule
